// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through FIFO capturing ALU {result, error, opcode},
// with a saturating error counter and a sticky drop flag for writes refused while full.
module alu_result_fifo #(
    parameter int DEPTH    = 8,
    parameter int DATA_W   = 32,
    parameter int OP_W     = 3,
    parameter int ERRCNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_result,
    input  logic                       in_error,
    input  logic [OP_W-1:0]            in_opcode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_result,
    output logic                       out_error,
    output logic [OP_W-1:0]            out_opcode,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [ERRCNT_W-1:0]        err_count,
    output logic                       drop_sticky
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + 1 + OP_W;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_en, rd_en;

    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign wr_en     = in_valid && !full;
    assign rd_en     = !empty && out_ready;
    assign {out_result, out_error, out_opcode} = empty ? '0 : mem[rd_ptr];

    // Storage carries no reset; a flush only needs to suppress the write.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) mem[wr_ptr] <= {in_result, in_error, in_opcode};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            err_count   <= '0;
            drop_sticky <= 1'b0;
        end else if (clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            err_count   <= '0;
            drop_sticky <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(rd_en);
            if (wr_en && in_error && err_count != '1) err_count <= err_count + 1'b1;
            if (in_valid && full) drop_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: randomized scenarios against a queue-based reference model;
// a second instance with a 2-bit error counter checks saturation on the same stimulus.
module tb_alu_result_fifo;
    typedef struct packed {logic [31:0] r; logic e; logic [2:0] op;} ent_t;

    logic clk = 0, rst = 0, clr = 0, in_valid = 0, in_error = 0, out_ready = 0;
    logic [31:0] in_result = 0;
    logic [2:0]  in_opcode = 0;
    logic        in_ready, out_valid, out_error, full, empty, drop_sticky;
    logic [31:0] out_result;
    logic [2:0]  out_opcode;
    logic [3:0]  count;
    logic [15:0] err_count;
    logic        s_in_ready, s_out_valid, s_out_error, s_full, s_empty, s_drop;
    logic [31:0] s_out_result;
    logic [2:0]  s_out_opcode;
    logic [3:0]  s_count;
    logic [1:0]  s_err_count;

    ent_t q[$];
    int   err_m = 0, err_s = 0;
    bit   drop_m = 0;
    int   tests = 0, fails = 0;

    alu_result_fifo dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_error(in_error), .in_opcode(in_opcode),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_error(out_error), .out_opcode(out_opcode), .count(count), .full(full),
        .empty(empty), .err_count(err_count), .drop_sticky(drop_sticky)
    );

    alu_result_fifo #(.ERRCNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_result(in_result), .in_error(in_error), .in_opcode(in_opcode),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result),
        .out_error(s_out_error), .out_opcode(s_out_opcode), .count(s_count), .full(s_full),
        .empty(s_empty), .err_count(s_err_count), .drop_sticky(s_drop)
    );

    always #5 clk = ~clk;

    // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
    task automatic cycle(input bit iv, input logic [31:0] r, input bit e, input logic [2:0] op,
                         input bit ordy, input bit c = 0);
        bit acc, rd, drp;
        ent_t x;
        in_valid = iv; in_result = r; in_error = e; in_opcode = op; out_ready = ordy; clr = c;
        acc = iv && q.size() < 8;
        rd  = q.size() > 0 && ordy;
        drp = iv && q.size() == 8;
        @(posedge clk);
        if (c) begin
            q.delete(); err_m = 0; err_s = 0; drop_m = 0;
        end else begin
            if (rd) x = q.pop_front();
            if (acc) q.push_back('{r, e, op});
            if (acc && e) begin
                if (err_m < 65535) err_m++;
                if (err_s < 3) err_s++;
            end
            if (drp) drop_m = 1;
        end
        @(negedge clk);
        in_valid = 0; out_ready = 0; clr = 0;
    endtask

    task automatic flush();
        cycle(0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        rst = 0;
        #3;
        tests += 7;
        if (empty !== 1) begin fails++; $display("FAIL reset_empty got %0b want 1", empty); end
        if (out_valid !== 0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        if (count !== 0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        if (err_count !== 0) begin fails++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        if (out_result !== 0) begin fails++; $display("FAIL reset_out_result got %h want 0", out_result); end
        if (in_ready !== 1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        if (drop_sticky !== 0) begin fails++; $display("FAIL reset_drop got %0b want 0", drop_sticky); end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_ordering();
        for (int i = 0; i < 3; i++) cycle(1, 32'(i + 1), 0, 3'(i), 0);
        tests++;
        if (count !== 3) begin fails++; $display("FAIL order_count got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            tests += 3;
            if (out_valid !== 1) begin fails++; $display("FAIL order_valid[%0d] got %0b want 1", i, out_valid); end
            if (out_result !== 32'(i + 1)) begin fails++; $display("FAIL order_result[%0d] got %h want %h", i, out_result, i + 1); end
            if (out_opcode !== 3'(i)) begin fails++; $display("FAIL order_opcode[%0d] got %0d want %0d", i, out_opcode, i); end
            cycle(0, 0, 0, 0, 1);
        end
        tests++;
        if (empty !== 1) begin fails++; $display("FAIL order_empty got %0b want 1", empty); end
    endtask

    task automatic test_full_drop();
        flush();
        for (int i = 0; i < 8; i++) cycle(1, $urandom, 1'($urandom), 3'($urandom), 0);
        tests += 2;
        if (full !== 1) begin fails++; $display("FAIL full_flag got %0b want 1", full); end
        if (in_ready !== 0) begin fails++; $display("FAIL full_in_ready got %0b want 0", in_ready); end
        cycle(1, 32'hDEAD, 0, 0, 0);
        tests += 2;
        if (drop_sticky !== 1) begin fails++; $display("FAIL drop_sticky got %0b want 1", drop_sticky); end
        if (count !== 8) begin fails++; $display("FAIL drop_count got %0d want 8", count); end
        for (int i = 0; i < 8; i++) begin
            tests += 2;
            if (out_result !== q[0].r || out_opcode !== q[0].op || out_error !== q[0].e) begin
                fails++; $display("FAIL drain_head[%0d] got %h/%0d/%0b want %h/%0d/%0b", i,
                                  out_result, out_opcode, out_error, q[0].r, q[0].op, q[0].e);
            end
            if (out_result === 32'hDEAD) begin fails++; $display("FAIL drain_dead[%0d] got %h", i, out_result); end
            cycle(0, 0, 0, 0, 1);
        end
        tests += 2;
        if (empty !== 1) begin fails++; $display("FAIL drain_empty got %0b want 1", empty); end
        if (drop_sticky !== 1) begin fails++; $display("FAIL drop_held got %0b want 1", drop_sticky); end
        flush();
        tests++;
        if (drop_sticky !== 0) begin fails++; $display("FAIL drop_clr got %0b want 0", drop_sticky); end
    endtask

    task automatic test_wrap();
        flush();
        for (int i = 0; i < 4; i++) cycle(1, $urandom, 0, 3'($urandom), 0);
        for (int i = 0; i < 20; i++) begin
            tests += 2;
            if (count !== 4) begin fails++; $display("FAIL wrap_count[%0d] got %0d want 4", i, count); end
            if (out_result !== q[0].r || out_opcode !== q[0].op) begin
                fails++; $display("FAIL wrap_head[%0d] got %h/%0d want %h/%0d", i, out_result, out_opcode, q[0].r, q[0].op);
            end
            cycle(1, $urandom, 0, 3'($urandom), 1);
        end
    endtask

    task automatic test_errors();
        flush();
        for (int i = 0; i < 5; i++) cycle(1, $urandom, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, $urandom, 0, 0, 0);
        cycle(1, $urandom, 1, 0, 0);
        tests += 3;
        if (err_count !== 5 || err_m != 5) begin fails++; $display("FAIL err_count got %0d want 5", err_count); end
        if (s_err_count !== 3) begin fails++; $display("FAIL err_sat got %0d want 3", s_err_count); end
        if (drop_sticky !== 1) begin fails++; $display("FAIL err_drop got %0b want 1", drop_sticky); end
        for (int i = 0; i < 4; i++) cycle(1, $urandom, 1, 0, 1);
        tests += 2;
        if (s_err_count !== 2'(err_s)) begin fails++; $display("FAIL err_sat_hold got %0d want %0d", s_err_count, err_s); end
        if (err_count !== 16'(err_m)) begin fails++; $display("FAIL err_more got %0d want %0d", err_count, err_m); end
    endtask

    task automatic test_clr_reset();
        flush();
        for (int i = 0; i < 5; i++) cycle(1, $urandom, 1, 0, 0);
        tests++;
        if (count !== 5) begin fails++; $display("FAIL clr_pre_count got %0d want 5", count); end
        cycle(1, $urandom, 1, 0, 1, 1);
        tests += 4;
        if (count !== 0) begin fails++; $display("FAIL clr_count got %0d want 0", count); end
        if (empty !== 1) begin fails++; $display("FAIL clr_empty got %0b want 1", empty); end
        if (err_count !== 0) begin fails++; $display("FAIL clr_err got %0d want 0", err_count); end
        if (drop_sticky !== 0) begin fails++; $display("FAIL clr_drop got %0b want 0", drop_sticky); end
        for (int i = 0; i < 9; i++) cycle(1, $urandom, 1, 0, 0);
        in_valid = 1; out_ready = 1;
        #2 rst = 0;
        #1;
        q.delete(); err_m = 0; err_s = 0; drop_m = 0;
        tests += 5;
        if (count !== 0) begin fails++; $display("FAIL rst_count got %0d want 0", count); end
        if (empty !== 1) begin fails++; $display("FAIL rst_empty got %0b want 1", empty); end
        if (err_count !== 0) begin fails++; $display("FAIL rst_err got %0d want 0", err_count); end
        if (drop_sticky !== 0) begin fails++; $display("FAIL rst_drop got %0b want 0", drop_sticky); end
        if (out_result !== 0) begin fails++; $display("FAIL rst_out_result got %h want 0", out_result); end
        @(negedge clk);
        in_valid = 0; out_ready = 0; rst = 1;
        @(negedge clk);
    endtask

    task automatic test_random();
        flush();
        for (int i = 0; i < 300; i++) begin
            ent_t h;
            h = q.size() ? q[0] : '0;
            tests++;
            if (count !== 4'(q.size()) || full !== (q.size() == 8) || empty !== (q.size() == 0) ||
                in_ready !== (q.size() < 8) || out_valid !== (q.size() > 0) ||
                out_result !== h.r || out_error !== h.e || out_opcode !== h.op ||
                err_count !== 16'(err_m) || s_err_count !== 2'(err_s) || drop_sticky !== drop_m) begin
                fails++;
                $display("FAIL rand[%0d] got cnt=%0d head=%h/%0b/%0d err=%0d/%0d drop=%0b want cnt=%0d head=%h/%0b/%0d err=%0d/%0d drop=%0b",
                         i, count, out_result, out_error, out_opcode, err_count, s_err_count, drop_sticky,
                         q.size(), h.r, h.e, h.op, err_m, err_s, drop_m);
            end
            cycle($urandom_range(0, 99) < 60, $urandom, 1'($urandom), 3'($urandom),
                  $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_ordering();
        test_full_drop();
        test_wrap();
        test_errors();
        test_clr_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
